// File: rtl/rf_phoenix_quad_wb.sv
// rf_phoenix_quad_wb: writeback stage for the 128-bit quad ALU.
// Quad results are queued in a small circular buffer and each one is retired
// as two 64-bit register-file writes: the low half to the even register of the
// pair, then the high half to the odd register.
// Optional feature macro: RF_PHOENIX_WB_HAZARD_EN enables the chk_reg/chk_hit
// pending-write hazard query; without it chk_hit is tied low.
module rf_phoenix_quad_wb #(
  parameter int DEPTH = 4,
  parameter int RW    = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic [RW-1:0]            res_rt,
  input  logic [127:0]             res_val,
  input  logic                     wb_stall,
  output logic                     wb_en,
  output logic [RW-1:0]            wb_addr,
  output logic [63:0]              wb_data,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [RW-1:0]            chk_reg,
  output logic                     chk_hit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [PW-1:0]  head_q;
  logic [PW-1:0]  tail_q;
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  post_pop;
  logic           push;
  logic           pop;
  logic           unused_bits;

  // Only the pair base is stored; bit0 of the destination is always implied 0.
  logic [RW-2:0]  rt_mem  [DEPTH];
  logic [127:0]   val_mem [DEPTH];

  assign count     = count_q;
  assign res_ready = (count_q < DEPTH_C);
  assign push      = res_valid & res_ready & ~flush;
  assign post_pop  = count_q - CW'(1) + CW'(push);

  // Next-state logic: walk LO then HI per entry, chaining straight into the next entry.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) state_d = LO;
      end
      LO: begin
        if (!wb_stall) state_d = HI;
      end
      HI: begin
        if (!wb_stall) begin
          pop     = 1'b1;
          state_d = (post_pop != '0) ? LO : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      pop     = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Queue pointers and occupancy; flush discards everything including a half-written entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; contents only matter once the pointers say the slot is occupied.
  always_ff @(posedge clk) begin
    if (push && rst_n) begin
      rt_mem[tail_q]  <= res_rt[RW-1:1];
      val_mem[tail_q] <= res_val;
    end
  end

  // Write port drive, decoded from the state and the head entry.
  always_comb begin
    wb_en   = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    case (state_q)
      LO: begin
        wb_en   = 1'b1;
        wb_addr = {rt_mem[head_q], 1'b0};
        wb_data = val_mem[head_q][63:0];
      end
      HI: begin
        wb_en   = 1'b1;
        wb_addr = {rt_mem[head_q], 1'b1};
        wb_data = val_mem[head_q][127:64];
      end
      default: ;
    endcase
  end

`ifdef RF_PHOENIX_WB_HAZARD_EN
  // Hazard query: match the register pair against every occupied slot, head included.
  always_comb begin
    chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PW'(i) - head_q} < count_q) && (rt_mem[i] == chk_reg[RW-1:1]))
        chk_hit = 1'b1;
    end
  end
  assign unused_bits = res_rt[0] ^ chk_reg[0];
`else
  assign chk_hit     = 1'b0;
  assign unused_bits = res_rt[0] ^ (^chk_reg);
`endif

endmodule

// File: doc/rf_phoenix_quad_wb.md
RF_PHOENIX_QUAD_WB -- requirements
Module: rf_phoenix_quad_wb

Downstream writeback stage for the 128-bit quad ALU. It queues quad results and retires each one as two 64-bit register-file writes to an even/odd register pair.

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 SHALL have parameter DEPTH, default 4, meaning result queue entries (power of two, >=2).
REQ-003 SHALL have parameter RW, default 6, meaning register address width.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port flush  in  1  synchronous queue discard.
REQ-007 SHALL have port res_valid  in  1  ALU result present.
REQ-008 SHALL have port res_ready  out  1  queue can accept.
REQ-009 SHALL have port res_rt  in  RW  destination pair base; bit0 ignored.
REQ-010 SHALL have port res_val  in  128  quad result.
REQ-011 SHALL have port wb_stall  in  1  register-file port busy; current beat not taken.
REQ-012 SHALL have port wb_en  out  1  write strobe.
REQ-013 SHALL have port wb_addr  out  RW  write address.
REQ-014 SHALL have port wb_data  out  64  write data.
REQ-015 SHALL have port count  out  $clog2(DEPTH)+1  occupied entries.
REQ-016 SHALL have port chk_reg  in  RW  hazard query register.
REQ-017 SHALL have port chk_hit  out  1  query matches a pending write.

Function
REQ-018 SHALL drive res_ready = (count < DEPTH), independent of res_valid and of a same-cycle pop; a full queue never accepts, even while popping.
REQ-019 SHALL push {res_rt with bit0 forced 0, res_val} at the tail on a rising edge with res_valid & res_ready & !flush.
REQ-020 SHALL wrap head and tail pointers modulo DEPTH.
REQ-021 SHALL use FSM states IDLE, LO and HI, held in registers; wb_* outputs SHALL be combinational from the state and the head entry.
REQ-022 IDLE: wb_en=0, wb_addr=0, wb_data=0; next state is LO when count>0 at a clock edge.
REQ-023 LO: wb_en=1, wb_addr={head.rt[RW-1:1],0}, wb_data=head.val[63:0]; next state is HI if !wb_stall, else hold LO.
REQ-024 HI: wb_en=1, wb_addr={head.rt[RW-1:1],1}, wb_data=head.val[127:64]; if !wb_stall, pop the head and go to LO when the post-pop count>0, else IDLE; if wb_stall, hold HI.
REQ-025 SHALL present the LO beat of a result pushed into an empty queue at edge N in cycle N+1 (one-cycle latency); the minimum retire time SHALL be 2 cycles per result.
REQ-026 A same-edge push and pop SHALL leave count unchanged, and the pushed entry SHALL follow the popped entry in order.
REQ-027 flush SHALL clear count and both pointers and force IDLE at the next edge; it overrides a same-cycle push and pop, and an abandoned HI beat is not completed.
REQ-028 wb_stall SHALL be ignored in IDLE.

Reset
REQ-029 While rst_n=0, the block SHALL asynchronously force state=IDLE, head=tail=0, count=0, wb_en=0, wb_addr=0, wb_data=0, chk_hit=0, res_ready=1.
REQ-030 No push SHALL occur on any edge at which rst_n=0; reset mid-beat SHALL drop all entries.

Configuration
REQ-031 With RF_PHOENIX_WB_HAZARD_EN defined, chk_hit SHALL be combinational and =1 when chk_reg[RW-1:1] equals rt[RW-1:1] of any occupied entry (including the head in LO or HI).
REQ-032 Without RF_PHOENIX_WB_HAZARD_EN, chk_hit SHALL be tied 0, chk_reg unused, and no comparators SHALL be synthesized.

Verification
REQ-033 Push rt=5, val=128'h1111..._2222... into an empty queue, no stall -> cycle+1: wb_en=1, addr=4, data=64'h2222...; cycle+2: addr=5, data=64'h1111...; then IDLE with count=0.
REQ-034 Push four results back-to-back with wb_stall held high -> count=4, res_ready=0, and a fifth push is ignored; release the stall -> 8 beats in push order, res_ready=1 after the first pop.
REQ-035 Assert wb_stall for 3 cycles during HI -> addr/data held stable for those 3 cycles; the pop occurs only on the first unstalled edge.
REQ-036 Assert flush together with res_valid while in HI, count=2 -> next cycle count=0, IDLE, wb_en=0, and the flushed push is absent.
REQ-037 With the macro defined, two pending entries rt=8 and rt=12: chk_reg=9 -> chk_hit=1; chk_reg=10 -> 0; with the macro undefined -> always 0.
REQ-038 Drop rst_n asynchronously mid-LO with count=3 -> wb_en=0 and count=0 immediately; after release the first push completes normally.
